mont_mult_arbiter: RTL and testbench

//   Round-robin arbiter sharing one Montgomery multiplier among NREQ requesters
//   (exponentiation ladder, R^2 pre-/post-conversion units).

---
 rtl/mont_mult_arbiter_if.sv | 39 +++
 rtl/mont_mult_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mont_mult_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mont_mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mont_mult_arbiter_if
// Brief    : Requester and multiplier signal bundle for mont_mult_arbiter.
// Revision : 1.0
// ============================================================================
interface mont_mult_arbiter_if #(
    parameter int WIDTH = 512,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*WIDTH-1:0] req_m;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       req_done;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic                  timeout_err;
    logic                  mm_start;
    logic [WIDTH-1:0]      mm_a;
    logic [WIDTH-1:0]      mm_b;
    logic [WIDTH-1:0]      mm_m;
    logic                  mm_done;
    logic [WIDTH-1:0]      mm_result;

    // Arbiter view
    modport slave (
        input  req, req_a, req_b, req_m, mm_done, mm_result,
        output gnt, req_done, result, busy, timeout_err, mm_start, mm_a, mm_b, mm_m
    );

    // Requester/multiplier environment view
    modport master (
        output req, req_a, req_b, req_m, mm_done, mm_result,
        input  gnt, req_done, result, busy, timeout_err, mm_start, mm_a, mm_b, mm_m
    );
endinterface
`default_nettype wire

// File: rtl/mont_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mont_mult_arbiter
// Brief    : Round-robin arbiter sharing one Montgomery multiplier among NREQ
//            requesters; optional watchdog enabled by MM_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mont_mult_arbiter #(
    parameter int WIDTH          = 512,
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mont_mult_arbiter_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   req_done_q, req_done_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  mm_a_q, mm_a_d;
    logic [WIDTH-1:0]  mm_b_q, mm_b_d;
    logic [WIDTH-1:0]  mm_m_q, mm_m_d;
    logic              mm_start_q, mm_start_d;

    logic              found;
    logic [PTR_W-1:0]  pick;
    int                idx;

`ifdef MM_ARB_TIMEOUT_EN
    logic [15:0]       tmo_q, tmo_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    // First requester at or above rr_ptr, wrapping NREQ-1 -> 0
    always_comb begin : arbitrate
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        gnt_d      = gnt_q;
        req_done_d = '0;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        result_d   = result_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_m_d     = mm_m_q;
        mm_start_d = 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
        tmo_d         = tmo_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    sel_d       = pick;
                    mm_a_d      = bus.req_a[int'(pick)*WIDTH +: WIDTH];
                    mm_b_d      = bus.req_b[int'(pick)*WIDTH +: WIDTH];
                    mm_m_d      = bus.req_m[int'(pick)*WIDTH +: WIDTH];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mm_start_d = 1'b1;
                state_d    = S_WAIT;
`ifdef MM_ARB_TIMEOUT_EN
                tmo_d      = '0;
`endif
            end
            S_WAIT: begin
                if (bus.mm_done) begin
                    result_d          = bus.mm_result;
                    req_done_d[sel_q] = 1'b1;
                    state_d           = S_DELIVER;
                end
`ifdef MM_ARB_TIMEOUT_EN
                // Counter reads 0 in the first WAIT cycle, so the abort lands
                // exactly TIMEOUT_CYCLES cycles after WAIT was entered.
                else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    result_d          = '0;
                    req_done_d[sel_q] = 1'b1;
                    timeout_err_d     = 1'b1;
                    state_d           = S_DELIVER;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            S_DELIVER: begin
                gnt_d    = '0;
                rr_ptr_d = (sel_q == PTR_W'(NREQ - 1)) ? '0 : sel_q + PTR_W'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            req_done_q <= '0;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            req_done_q <= req_done_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            result_q   <= result_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_m_q     <= mm_m_d;
            mm_start_q <= mm_start_d;
        end
    end

`ifdef MM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign bus.timeout_err    = 1'b0;
`endif

    assign bus.gnt      = gnt_q;
    assign bus.req_done = req_done_q;
    assign bus.result   = result_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.mm_start = mm_start_q;
    assign bus.mm_a     = mm_a_q;
    assign bus.mm_b     = mm_b_q;
    assign bus.mm_m     = mm_m_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mont_mult_arbiter
// Brief    : Directed self-checking bench for mont_mult_arbiter (two
//            requesters); the watchdog step runs when MM_ARB_TIMEOUT_EN is set.
// Revision : 1.0
// ============================================================================
module tb_mont_mult_arbiter;
    localparam int WIDTH = 512;
    localparam int NREQ  = 2;
    localparam int TMO   = 16;
    localparam logic [WIDTH-1:0] M0 = 512'hD97A_3C51_0E88_47B2_9F16_A4C3_5E07_2B85;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [WIDTH-1:0] opa [NREQ];
    logic [WIDTH-1:0] opb [NREQ];
    logic [WIDTH-1:0] opm [NREQ];

    mont_mult_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    mont_mult_arbiter #(
        .WIDTH          (WIDTH),
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = opa[i];
            bus.req_b[i*WIDTH +: WIDTH] = opb[i];
            bus.req_m[i*WIDTH +: WIDTH] = opm[i];
        end
    endtask

    // Precondition: DUT is IDLE this cycle with req[e] set so the next edge grants e.
    // The multiplier answers (a*b) mod m from the operands it was handed.
    task automatic do_job(input int e, input int lat, input int hold, input bit drop,
                          input logic [WIDTH-1:0] exp_res);
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[e] = 1'b1;
        tick();
        chk("gnt", WIDTH'(bus.gnt), WIDTH'(oh));
        chk("busy_job", WIDTH'(bus.busy), WIDTH'(1));
        chk("mm_a", bus.mm_a, opa[e]);
        chk("mm_b", bus.mm_b, opb[e]);
        chk("mm_m", bus.mm_m, opm[e]);
        chk("mm_start_pre", WIDTH'(bus.mm_start), WIDTH'(0));
        bus.req_a[e*WIDTH +: WIDTH] = ~opa[e];
        if (drop) bus.req[e] = 1'b0;
        tick();
        chk("mm_start", WIDTH'(bus.mm_start), WIDTH'(1));
        tick();
        chk("mm_start_once", WIDTH'(bus.mm_start), WIDTH'(0));
        chk("mm_a_held", bus.mm_a, opa[e]);
        repeat (lat - 1) tick();
        chk("no_early_done", WIDTH'(bus.req_done), WIDTH'(0));
        bus.mm_done   = 1'b1;
        bus.mm_result = (bus.mm_a * bus.mm_b) % bus.mm_m;
        tick();
        chk("req_done", WIDTH'(bus.req_done), WIDTH'(oh));
        chk("result", bus.result, exp_res);
        chk("gnt_deliver", WIDTH'(bus.gnt), WIDTH'(oh));
        for (int h = 1; h < hold; h++) begin
            tick();
            chk("single_done", WIDTH'(bus.req_done), WIDTH'(0));
        end
        bus.mm_done   = 1'b0;
        bus.mm_result = '0;
        if (hold == 1) tick();
        chk("idle_busy", WIDTH'(bus.busy), WIDTH'(0));
        chk("idle_gnt", WIDTH'(bus.gnt), WIDTH'(0));
        chk("idle_done", WIDTH'(bus.req_done), WIDTH'(0));
        pack();
    endtask

    initial begin
        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_m     = '0;
        bus.mm_done   = 1'b0;
        bus.mm_result = '0;
        opa[0] = 512'd2;  opb[0] = 512'd3;  opm[0] = M0;
        opa[1] = 512'd11; opb[1] = 512'd13; opm[1] = 512'd100;
        pack();

        // Reset values
        repeat (3) tick();
        chk("rst_gnt", WIDTH'(bus.gnt), WIDTH'(0));
        chk("rst_busy", WIDTH'(bus.busy), WIDTH'(0));
        chk("rst_done", WIDTH'(bus.req_done), WIDTH'(0));
        chk("rst_result", bus.result, '0);
        chk("rst_start", WIDTH'(bus.mm_start), WIDTH'(0));
        chk("rst_mm_a", bus.mm_a, '0);
        chk("rst_tmo", WIDTH'(bus.timeout_err), WIDTH'(0));
        reset = 1'b0;

        // Single requester, multiplier answers 10 cycles after start: 2*3 = 6
        bus.req = 2'b01;
        do_job(0, 10, 1, 1'b1, 512'd6);

        // Both requesting from reset: order 0,1,0,1 with one idle cycle between
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        opa[0] = 512'd5;
        opb[0] = 512'd7;
        pack();
        bus.req = 2'b11;
        do_job(0, 4, 1, 1'b0, 512'd35);
        do_job(1, 3, 1, 1'b0, 512'd43);
        do_job(0, 2, 1, 1'b0, 512'd35);
        do_job(1, 5, 1, 1'b0, 512'd43);
        bus.req = 2'b00;

        // Request dropped right after grant still completes: 9*7 = 63
        opa[0] = 512'd9;
        pack();
        bus.req = 2'b01;
        do_job(0, 5, 1, 1'b1, 512'd63);
        tick();
        chk("drop_stays_idle", WIDTH'(bus.busy), WIDTH'(0));

        // Reset three cycles into WAIT
        bus.req = 2'b10;
        tick();
        chk("pre_rst_gnt", WIDTH'(bus.gnt), WIDTH'(2'b10));
        bus.req = 2'b00;
        repeat (4) tick();
        chk("wait_busy", WIDTH'(bus.busy), WIDTH'(1));
        reset = 1'b1;
        tick();
        chk("mid_rst_gnt", WIDTH'(bus.gnt), WIDTH'(0));
        chk("mid_rst_busy", WIDTH'(bus.busy), WIDTH'(0));
        chk("mid_rst_done", WIDTH'(bus.req_done), WIDTH'(0));
        chk("mid_rst_mm_a", bus.mm_a, '0);
        chk("mid_rst_result", bus.result, '0);
        reset  = 1'b0;
        opa[0] = 512'd4;
        pack();
        bus.req = 2'b01;
        do_job(0, 3, 1, 1'b1, 512'd28);

        // mm_done held 4 cycles, spilling into IDLE: 6*7 = 42
        opa[0] = 512'd6;
        pack();
        bus.req = 2'b01;
        do_job(0, 3, 4, 1'b1, 512'd42);
        tick();
        chk("spurious_idle", WIDTH'(bus.busy), WIDTH'(0));
        chk("spurious_result", bus.result, 512'd42);

`ifdef MM_ARB_TIMEOUT_EN
        // Multiplier never answers: abort 16 cycles after WAIT entry
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        chk("tmo_start", WIDTH'(bus.mm_start), WIDTH'(1));
        repeat (15) tick();
        chk("tmo_not_yet", WIDTH'(bus.req_done), WIDTH'(0));
        tick();
        chk("tmo_done", WIDTH'(bus.req_done), WIDTH'(2'b01));
        chk("tmo_result", bus.result, '0);
        chk("tmo_err", WIDTH'(bus.timeout_err), WIDTH'(1));
        repeat (3) tick();
        chk("tmo_sticky", WIDTH'(bus.timeout_err), WIDTH'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("tmo_cleared", WIDTH'(bus.timeout_err), WIDTH'(0));
`else
        chk("tmo_tied", WIDTH'(bus.timeout_err), WIDTH'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
